cache_mem_ctrl: RTL and testbench
=================================

Name: cache_mem_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the CPU load/store path and the 128-bit-block main memory, and acts as the initiator on the memory's isMemRead/isLock interface.
- Services 32-bit word accesses from the CPU.
- On a miss it evicts the victim block if dirty, then refills the requested block from memory.

Parameters:
- NUM_LINES, 4: cache lines; index width = log2(NUM_LINES).
- MEM_LATENCY, 2: cycles the memory interface is held unlocked per transaction; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  access request; held high until cpu_ready seen.
- cpu_write  in  1  1 = store, 0 = load; stable while cpu_req high.
- cpu_addr  in  10  byte address; [1:0] ignored, [3:2] word offset, [5:4] index, [9:6] tag.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid only while cpu_ready high.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_read  out  1  drives memory isMemRead (1 = read, 0 = write).
- mem_lock  out  1  drives memory isLock (1 = memory idle / no access).
- mem_addr  out  10  block byte address; [3:0] always 0.
- mem_wdata  out  128  write-back block.
- mem_rdata  in  128  refill block from memory (combinational read).

Behaviour:
- Block layout: word k of a block = bits [32k+31:32k].
- Per line: valid, dirty, 4-bit tag, 128-bit data.
- All outputs are registered.
- Reset (rst_n low at an edge), effective on the next cycle:
  - state = IDLE; all valid and dirty bits cleared.
  - cpu_ready = 0, cpu_rdata = 0.
  - mem_lock = 1, mem_read = 1, mem_addr = 0, mem_wdata = 0.
  - Reset mid-transaction aborts it; mem_lock returns to 1 immediately.
- Memory safety rule: the memory writes whenever isLock = 0 and isMemRead = 0. Therefore mem_read, mem_addr and mem_wdata change only in cycles where mem_lock = 1. mem_lock = 0 only in the unlocked phase of WB and AL.
- States:
  - IDLE:
    - If cpu_req = 1 and cpu_ready = 0: latch addr, write, wdata; go to CMP.
    - cpu_ready is cleared in IDLE after its one-cycle pulse.
  - CMP:
    - Hit (valid and tag match), load: cpu_rdata = selected word, cpu_ready = 1 next cycle, go to IDLE.
    - Hit, store: merge the word into the line, set dirty, cpu_ready = 1, go to IDLE.
    - Miss with valid and dirty victim: go to WB.
    - Miss otherwise: go to AL.
  - WB:
    - Setup cycle: mem_lock = 1, mem_read = 0, mem_addr = {victim tag, index, 4'b0}, mem_wdata = line data.
    - Then MEM_LATENCY cycles with mem_lock = 0.
    - Then clear dirty, go to AL.
  - AL:
    - Setup cycle: mem_lock = 1, mem_read = 1, mem_addr = {req tag, index, 4'b0}.
    - Then MEM_LATENCY cycles with mem_lock = 0; capture mem_rdata on the last of these cycles.
    - Then mem_lock = 1; line valid = 1, dirty = 0, tag = req tag; go to CMP, which now hits.
- Latency, with cpu_req sampled at edge N:
  - Hit: cpu_ready high in cycle N+2.
  - Clean miss: N+2 + (1+MEM_LATENCY) + 1.
  - Dirty miss: adds another (1+MEM_LATENCY).
- Edge rules:
  - cpu_req changing while busy is ignored (request already latched).
  - A store to a dirty hit line leaves it dirty.
  - Back-to-back requests: the next cpu_req is accepted the cycle after cpu_ready.
  - A latency counter reaching MEM_LATENCY ends the phase; the counter resets to 0 on state entry.

Test Plan:
- Memory preload: block 0x000 = {word2 0x3cc3, word0 0x3}; block 0x200: word0 = 0x04000ccc, word2 = 0x0ccc; block 0x300: word0 = 0x040000c3, word2 = 0xc3.
- Reset, load 0x000 -> AL phase with mem_lock = 0, mem_read = 1, mem_addr = 0x000 for 2 cycles; cpu_ready pulse with cpu_rdata = 0x00000003. Then load 0x008 -> hit, cpu_rdata = 0x00003cc3 two cycles after req, mem_lock stays 1.
- Store 0xDEADBEEF to 0x004 (hit, dirty), then load 0x200 -> WB with mem_addr = 0x000, mem_wdata[63:32] = 0xDEADBEEF, mem_read = 0; then AL at 0x200; cpu_rdata = 0x04000ccc.
- Load 0x300 while line 0 is clean -> no WB phase (mem_read never 0), AL at 0x300, cpu_rdata = 0x040000c3.
- Store 0x12345678 to 0x01C (miss, index 1) -> AL at 0x010 only; later load 0x01C hits with 0x12345678; eviction via load 0x11C writes back mem_wdata[127:96] = 0x12345678.
- rst_n low during the WB unlocked phase -> next cycle mem_lock = 1, cpu_ready = 0; reload of 0x004 misses.
- Continuous check across all tests: mem_read, mem_addr and mem_wdata never change while mem_lock = 0.

Source files
------------

// File: rtl/cache_mem_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Evicts a dirty victim, then refills the requested 128-bit block over the isMemRead/isLock memory port.
//
// state | meaning
// IDLE  | waiting for a new CPU request
// CMP   | tag compare; a hit completes the access
// WB    | dirty victim write-back: one locked setup cycle, then MEM_LATENCY unlocked cycles
// AL    | block refill: one locked setup cycle, then MEM_LATENCY unlocked cycles
module cache_mem_ctrl #(
    parameter int NUM_LINES   = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_write,
    input  logic [9:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         mem_read,
    output logic         mem_lock,
    output logic [9:0]   mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 6 - IW;
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_WB,
        S_AL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_write_q, req_write_d;
    logic [9:0]      req_addr_q, req_addr_d;
    logic [31:0]     req_wdata_q, req_wdata_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    logic [31:0]     cpu_rdata_d;
    logic            cpu_ready_d;
    logic            mem_read_d;
    logic            mem_lock_d;
    logic [9:0]      mem_addr_d;
    logic [127:0]    mem_wdata_d;

    logic [IW-1:0]   idx;
    logic [TW-1:0]   rtag;
    logic [6:0]      sel;
    logic [127:0]    line;
    logic [127:0]    merged;
    logic            hit;
    logic            phase_done;
    logic            fill_we;
    logic            store_we;
    logic            clean_we;

    // Byte-offset bits carry no meaning for word accesses.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign idx        = req_addr_q[4 +: IW];
    assign rtag       = req_addr_q[4 + IW +: TW];
    assign sel        = {req_addr_q[3:2], 5'b0};
    assign line       = data_q[idx];
    assign hit        = valid_q[idx] && (tag_q[idx] == rtag);
    assign merged     = (line & ~(128'hffff_ffff << sel)) | ({96'b0, req_wdata_q} << sel);
    assign phase_done = (cnt_q == CW'(MEM_LATENCY));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        cpu_rdata_d = cpu_rdata;
        cpu_ready_d = 1'b0;
        mem_read_d  = mem_read;
        mem_lock_d  = mem_lock;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        fill_we     = 1'b0;
        store_we    = 1'b0;
        clean_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req && !cpu_ready) begin
                    req_write_d = cpu_write;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    state_d     = S_CMP;
                end
            end
            S_CMP: begin
                if (hit) begin
                    if (req_write_q) begin
                        store_we = 1'b1;
                    end else begin
                        cpu_rdata_d = line[sel +: 32];
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    // Address and data are set up while still locked, so a write never sees them move.
                    cnt_d       = '0;
                    mem_lock_d  = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_addr_d  = {tag_q[idx], idx, 4'b0};
                    mem_wdata_d = line;
                    state_d     = S_WB;
                end else begin
                    cnt_d      = '0;
                    mem_lock_d = 1'b1;
                    mem_read_d = 1'b1;
                    mem_addr_d = {rtag, idx, 4'b0};
                    state_d    = S_AL;
                end
            end
            S_WB: begin
                if (phase_done) begin
                    clean_we   = 1'b1;
                    cnt_d      = '0;
                    mem_lock_d = 1'b1;
                    mem_read_d = 1'b1;
                    mem_addr_d = {rtag, idx, 4'b0};
                    state_d    = S_AL;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    mem_lock_d = 1'b0;
                end
            end
            S_AL: begin
                if (phase_done) begin
                    fill_we    = 1'b1;
                    mem_lock_d = 1'b1;
                    state_d    = S_CMP;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    mem_lock_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            mem_read    <= 1'b1;
            mem_lock    <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            cpu_rdata   <= cpu_rdata_d;
            cpu_ready   <= cpu_ready_d;
            mem_read    <= mem_read_d;
            mem_lock    <= mem_lock_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            if (fill_we) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (store_we) begin
                dirty_q[idx] <= 1'b1;
            end else if (clean_we) begin
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Line storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (rst_n && fill_we) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= rtag;
        end else if (rst_n && store_we) begin
            data_q[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: a word-level view of memory plus a cache occupancy model predict
// completion timing, load data and memory-port activity for every cycle.
module tb_cache_mem_ctrl;

    localparam int ML = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_write;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         mem_read;
    logic         mem_lock;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;

    cache_mem_ctrl #(.NUM_LINES(4), .MEM_LATENCY(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_read  (mem_read),
        .mem_lock  (mem_lock),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // External memory: 64 blocks of 128 bits, combinational read, writes while unlocked and not reading.
    logic [127:0] mem [64];
    logic         preload;
    assign mem_rdata = mem[mem_addr[9:4]];

    always @(posedge clk) begin
        if (preload) begin
            for (int b = 0; b < 64; b++) mem[b] <= 128'h0;
            mem[6'h00] <= {32'h0, 32'h0000_3cc3, 32'h0, 32'h0000_0003};
            mem[6'h20] <= {32'h0, 32'h0000_0ccc, 32'h0, 32'h0400_0ccc};
            mem[6'h30] <= {32'h0, 32'h0000_00c3, 32'h0, 32'h0400_00c3};
        end else if (!mem_lock && !mem_read) begin
            mem[mem_addr[9:4]] <= mem_wdata;
        end
    end

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, ecnt, act, exp);
        end
    endtask

    // CPU-visible word image and cache occupancy model.
    logic [31:0] gold [256];
    bit          m_valid [4];
    bit          m_dirty [4];
    logic [3:0]  m_tag   [4];

    // Expected schedule of the current access, in edge counts.
    int           ready_e = -1;
    int           wb_lo = -1, wb_hi = -1, al_lo = -1, al_hi = -1;
    logic [9:0]   wb_addr, al_addr;
    logic [127:0] wb_data;
    logic [31:0]  exp_rdata;
    bit           exp_load;
    bit           run = 1'b0;

    function automatic logic [127:0] gold_block(input int b);
        return {gold[b*4+3], gold[b*4+2], gold[b*4+1], gold[b*4]};
    endfunction

    task automatic resync_model();
        for (int i = 0; i < 256; i++) gold[i] = mem[i/4][(i%4)*32 +: 32];
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 4'h0;
        end
    endtask

    task automatic start(input logic w, input logic [9:0] a, input logic [31:0] d, output int n);
        int  idx;
        bit  hit;
        bit  dv;
        @(posedge clk); #1;
        n   = ecnt + 1;
        idx = int'(a[5:4]);
        hit = m_valid[idx] && (m_tag[idx] == a[9:6]);
        dv  = !hit && m_valid[idx] && m_dirty[idx];
        wb_lo = -1; wb_hi = -1; al_lo = -1; al_hi = -1;
        if (hit) begin
            ready_e = n + 1;
        end else if (dv) begin
            wb_addr = {m_tag[idx], a[5:4], 4'h0};
            wb_data = gold_block(int'({m_tag[idx], a[5:4]}));
            wb_lo   = n + 2;       wb_hi = n + 1 + ML;
            al_lo   = n + 3 + ML;  al_hi = n + 2 + 2*ML;
            ready_e = n + 4 + 2*ML;
        end else begin
            al_lo   = n + 2;       al_hi = n + 1 + ML;
            ready_e = n + 3 + ML;
        end
        al_addr = {a[9:4], 4'h0};
        if (!hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[9:6];
            m_dirty[idx] = 1'b0;
        end
        exp_load = !w;
        if (w) begin
            m_dirty[idx] = 1'b1;
            gold[a[9:2]] = d;
        end else begin
            exp_rdata = gold[a[9:2]];
        end
        cpu_req   = 1'b1;
        cpu_write = w;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic finish(input bit rd_en, input logic [31:0] rd, input bit al_en,
                          input logic [9:0] al, input int wb_k, input logic [31:0] wb_w);
        do begin
            @(negedge clk);
            if (al_en && ecnt == al_lo) chk("lit_al_addr", mem_addr, al);
            if (wb_k >= 0 && ecnt == wb_lo) chk("lit_wb_word", mem_wdata[wb_k*32 +: 32], wb_w);
        end while (ecnt < ready_e);
        if (rd_en) chk("lit_rdata", cpu_rdata, rd);
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_mem_lock",  mem_lock,  1'b1);
        chk("rst_mem_read",  mem_read,  1'b1);
        chk("rst_cpu_ready", cpu_ready, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_addr",  mem_addr,  10'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
    endtask

    // Per-cycle compare against the schedule, plus the memory-port stability rule.
    logic         p_read;
    logic [9:0]   p_addr;
    logic [127:0] p_wdata;
    always @(negedge clk) begin
        bit in_wb, in_al;
        if (run && rst_n) begin
            in_wb = (ecnt >= wb_lo) && (ecnt <= wb_hi);
            in_al = (ecnt >= al_lo) && (ecnt <= al_hi);
            chk("cpu_ready", cpu_ready, ecnt == ready_e);
            if (ecnt == ready_e && exp_load) chk("cpu_rdata", cpu_rdata, exp_rdata);
            chk("mem_lock", mem_lock, !(in_wb || in_al));
            if (in_wb) begin
                chk("wb_mem_read",  mem_read,  1'b0);
                chk("wb_mem_addr",  mem_addr,  wb_addr);
                chk("wb_mem_wdata", mem_wdata, wb_data);
            end
            if (in_al) begin
                chk("al_mem_read", mem_read, 1'b1);
                chk("al_mem_addr", mem_addr, al_addr);
            end
            if (!mem_lock) begin
                chk("stable_mem_read",  mem_read,  p_read);
                chk("stable_mem_addr",  mem_addr,  p_addr);
                chk("stable_mem_wdata", mem_wdata, p_wdata);
            end
        end
        p_read  = mem_read;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n;
    initial begin
        rst_n = 1'b0; preload = 1'b1;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values();
        preload = 1'b0;
        rst_n   = 1'b1;
        resync_model();
        run = 1'b1;

        start(1'b0, 10'h000, 32'h0, n);          finish(1, 32'h0000_0003, 1, 10'h000, -1, 32'h0);
        start(1'b0, 10'h008, 32'h0, n);          finish(1, 32'h0000_3cc3, 0, 10'h000, -1, 32'h0);
        start(1'b1, 10'h004, 32'hDEAD_BEEF, n);  finish(0, 32'h0, 0, 10'h000, -1, 32'h0);
        start(1'b0, 10'h200, 32'h0, n);          finish(1, 32'h0400_0ccc, 1, 10'h200, 1, 32'hDEAD_BEEF);
        start(1'b0, 10'h300, 32'h0, n);          finish(1, 32'h0400_00c3, 1, 10'h300, -1, 32'h0);
        idle(2);

        // Inputs wander after acceptance; the latched request must be the one serviced.
        start(1'b1, 10'h01C, 32'h1234_5678, n);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 10'h3ff; cpu_wdata = 32'hFFFF_FFFF;
        finish(0, 32'h0, 1, 10'h010, -1, 32'h0);

        start(1'b0, 10'h01C, 32'h0, n);          finish(1, 32'h1234_5678, 0, 10'h000, -1, 32'h0);
        start(1'b1, 10'h018, 32'hA5A5_A5A5, n);  finish(0, 32'h0, 0, 10'h000, -1, 32'h0);
        start(1'b0, 10'h11C, 32'h0, n);          finish(1, 32'h0, 1, 10'h110, 3, 32'h1234_5678);
        start(1'b0, 10'h01C, 32'h0, n);          finish(1, 32'h1234_5678, 1, 10'h010, -1, 32'h0);
        start(1'b0, 10'h018, 32'h0, n);          finish(1, 32'hA5A5_A5A5, 0, 10'h000, -1, 32'h0);

        // Reset in the middle of a write-back.
        start(1'b1, 10'h004, 32'hCAFE_F00D, n);  finish(0, 32'h0, 1, 10'h000, -1, 32'h0);
        start(1'b0, 10'h204, 32'h0, n);
        while (ecnt < n + 2) begin
            @(posedge clk); #1;
        end
        chk("wb_unlocked_before_reset", mem_lock, 1'b0);
        rst_n = 1'b0; cpu_req = 1'b0;
        ready_e = -1; wb_lo = -1; wb_hi = -1; al_lo = -1; al_hi = -1;
        @(posedge clk); #1;
        chk_reset_values();
        rst_n = 1'b1;
        resync_model();
        idle(2);

        start(1'b0, 10'h004, 32'h0, n);          finish(0, 32'h0, 1, 10'h000, -1, 32'h0);
        start(1'b0, 10'h000, 32'h0, n);          finish(1, 32'h0000_0003, 0, 10'h000, -1, 32'h0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
